// File: rtl/mem_lsu_if.sv
// Pipeline-side request/response and memory-side bus signals of the load/store unit.
// The slave modport is the LSU's view; the master modport is the pipeline/memory environment's view.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: lane steering and byte enables for stores, lane extract and extension for
// loads, and a request/ack memory handshake with misalignment and timeout error reporting.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | ready for a new access (req_ready=1)
//   S_ACCESS | memory request outstanding (mem_en=1), counting wait cycles
//   S_RESP   | one-cycle completion pulse to the pipeline (resp_valid=1)
module mem_lsu #(
  parameter int WAIT_MAX = 16
) (
  input logic      clk,
  input logic      reset,
  mem_lsu_if.slave bus
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          we_q, sext_q;
  logic [1:0]    size_q, off_q;
  logic          misalign;
  logic          cnt_last;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.mem_en     = (state_q == S_ACCESS);
  assign cnt_last       = (cnt_q == CW'(WAIT_MAX - 1));

  always_comb begin
    misalign = 1'b0;
    case (bus.req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = bus.req_addr[0];
      2'd2:    misalign = |bus.req_addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // Store lane steering: narrow operands are replicated so every enabled lane sees the data.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = bus.req_wdata;
    case (bus.req_size)
      2'd0: begin
        be_d    = 4'b0001 << bus.req_addr[1:0];
        wdata_d = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        be_d    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = bus.req_wdata;
      end
    endcase
  end

  always_comb begin
    byte_sel = bus.mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'd0:    load_ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.req_valid) state_d = misalign ? S_RESP : S_ACCESS;
      S_ACCESS: if (bus.mem_ack || cnt_last) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      we_q           <= 1'b0;
      sext_q         <= 1'b0;
      size_q         <= 2'd0;
      off_q          <= 2'd0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_be     <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q   <= bus.req_we;
            sext_q <= bus.req_sext;
            size_q <= bus.req_size;
            off_q  <= bus.req_addr[1:0];
            if (misalign) begin
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              bus.mem_we    <= bus.req_we;
              bus.mem_be    <= be_d;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_wdata <= wdata_d;
            end
          end
        end
        S_ACCESS: begin
          if (bus.mem_ack) begin
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= we_q ? 32'd0 : load_ext;
            bus.mem_we     <= 1'b0;
          end else if (cnt_last) begin
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
            bus.mem_we     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP:  cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: randomized and directed accesses checked by scoreboard monitors on the
// response port and the memory bus against an arithmetic reference model.
module tb_mem_lsu;
  localparam int WAIT_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_lsu_if bus ();

  mem_lsu #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    last_resp_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: access rules in plain arithmetic.
  function automatic bit is_misaligned(input int size, input logic [31:0] addr);
    int a;
    a = int'(addr[1:0]);
    return (size == 3) || ((a % (1 << size)) != 0);
  endfunction

  function automatic logic [3:0] model_be(input int size, input int a);
    int n;
    n = 1 << size;
    return 4'(((1 << n) - 1) << a);
  endfunction

  function automatic logic [31:0] model_wdata(input int size, input logic [31:0] w);
    int n;
    logic [31:0] r;
    n = 1 << size;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input int size, input bit sext, input int a,
                                             input logic [31:0] word);
    logic [31:0] v, mask;
    v = word >> (8 * a);
    mask = (size == 2) ? 32'hFFFF_FFFF : ((32'd1 << (8 << size)) - 32'd1);
    v = v & mask;
    if (sext && size != 2 && v[(8 << size) - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_req(input bit we, input int size, input bit sext, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at,
                        input bit b2b);
    bit    mis;
    bit    tmo;
    int    a;
    int    acc;
    int    n;
    bus_t  b;
    resp_t r;
    mis = is_misaligned(size, addr);
    tmo = (ack_at == 0) || (ack_at > WAIT_MAX);
    a   = int'(addr[1:0]);
    b.cycles = 0;
    if (!mis) begin
      b.we     = we;
      b.be     = model_be(size, a);
      b.addr   = {addr[31:2], 2'b00};
      b.wdata  = model_wdata(size, wdata);
      b.cycles = tmo ? WAIT_MAX : ack_at;
      bus_q.push_back(b);
    end
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = 2'(size);
    bus.req_sext  = sext;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      $display("FAIL req_ready_wait actual=0 required=1 within 50 cycles");
      $fatal(1, "request never accepted");
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    acc = cyc;
    if (b2b) chk("b2b_gap", 32'(acc - last_resp_cyc), 32'd2);
    r.err   = mis || tmo;
    r.rdata = (we || mis || tmo) ? 32'd0 : model_load(size, sext, a, rdata);
    r.cyc   = acc + (mis ? 0 : b.cycles);
    resp_q.push_back(r);
    if (ack_at > 0) begin
      repeat (ack_at - 1) @(posedge clk);
      #1;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata;
      @(posedge clk);
      #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
    end
  endtask

  // Response monitor
  always @(negedge clk) begin : resp_mon
    resp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (resp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp actual=resp_valid required=no_response (t=%0t)", $time);
      end else begin
        e = resp_q.pop_front();
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
      last_resp_cyc = cyc;
    end
  end

  // Memory bus monitor
  bus_t cur;
  int   run = 0;
  bit   active = 1'b0;
  always @(negedge clk) begin : bus_mon
    if (bus.mem_en === 1'b1) begin
      if (!active) begin
        if (bus_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_mem_en actual=1 required=0 (t=%0t)", $time);
          cur.we = bus.mem_we; cur.be = bus.mem_be; cur.addr = bus.mem_addr;
          cur.wdata = bus.mem_wdata; cur.cycles = 0;
        end else begin
          cur = bus_q.pop_front();
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, cur.we});
          chk("mem_be", {28'd0, bus.mem_be}, {28'd0, cur.be});
          chk("mem_addr", bus.mem_addr, cur.addr);
          if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
        end
        active = 1'b1;
        run = 1;
      end else begin
        run++;
        chk("mem_we_stable", {31'd0, bus.mem_we}, {31'd0, cur.we});
        chk("mem_be_stable", {28'd0, bus.mem_be}, {28'd0, cur.be});
        chk("mem_addr_stable", bus.mem_addr, cur.addr);
        if (cur.we) chk("mem_wdata_stable", bus.mem_wdata, cur.wdata);
      end
    end else if (active) begin
      active = 1'b0;
      chk("mem_en_cycles", 32'(run), 32'(cur.cycles));
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || active) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_resp_q", 32'(resp_q.size()), 32'd0);
    chk("drain_bus_q", 32'(bus_q.size()), 32'd0);
  endtask

  initial begin
    bit          we;
    int          size;
    logic [31:0] addr;
    bus_t        b;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_sext  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);

    // Directed cases
    do_req(1'b1, 0, 1'b0, 32'h0000_1003, 32'h0000_00A5, $urandom, 2, 1'b0);
    do_req(1'b0, 1, 1'b1, 32'h0000_2002, $urandom, 32'h8001_1234, 1, 1'b0);
    do_req(1'b0, 1, 1'b0, 32'h0000_2002, $urandom, 32'h8001_1234, 3, 1'b0);
    do_req(1'b0, 1, 1'b1, 32'h0000_2000, $urandom, 32'h8001_1234, 2, 1'b0);
    do_req(1'b0, 0, 1'b0, 32'h0000_0001, $urandom, 32'h1122_3344, 1, 1'b0);
    do_req(1'b0, 0, 1'b1, 32'h0000_0003, $urandom, 32'h8000_0000, 2, 1'b1);
    do_req(1'b0, 2, 1'b0, 32'h0000_3001, $urandom, $urandom, 1, 1'b0);
    do_req(1'b0, 3, 1'b0, 32'h0000_4000, $urandom, $urandom, 2, 1'b1);
    do_req(1'b0, 2, 1'b0, 32'h0000_5000, $urandom, $urandom, 0, 1'b0);
    do_req(1'b1, 1, 1'b0, 32'h0000_5006, 32'hCAFE_BEEF, $urandom, 0, 1'b0);
    do_req(1'b1, 2, 1'b0, 32'h0000_7004, 32'h1234_5678, $urandom, WAIT_MAX, 1'b0);

    // Randomized traffic, mostly aligned, acks from immediate to past the timeout
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom % 2);
      size = int'($urandom % 4);
      addr = $urandom;
      if (($urandom % 4) != 0 && size < 3) addr = addr & ~((32'd1 << size) - 32'd1);
      do_req(we, size, 1'($urandom % 2), addr, $urandom, $urandom,
             int'($urandom_range(0, WAIT_MAX + 2)), 1'b0);
    end
    drain();

    // Reset during the second ACCESS cycle, followed by a late ack
    b.we = 1'b0; b.be = 4'hF; b.addr = 32'h0000_6000; b.wdata = '0; b.cycles = 2;
    bus_q.push_back(b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_sext  = 1'b0;
    bus.req_addr  = 32'h0000_6000;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rstmid_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rstmid_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstmid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rstmid_resp_err", {31'd0, bus.resp_err}, 32'd0);
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rstmid_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    drain();

    // Unit still works after the mid-access reset
    do_req(1'b0, 0, 1'b1, 32'h0000_8002, $urandom, 32'h00F0_0000, 1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
